counter_prescaler: RTL and testbench
====================================

Name: counter_prescaler

Overview:
- Upstream neighbour of the pipeline's up-counter. Generates the counter's single-cycle `enable` strobe, one pulse every DIV clock cycles.
- Has a start/stop/one-shot control FSM and a glitch-free divide-ratio update.
- Typical uses: slow peripheral timers, cycle-stepping the debug program counter.

Parameters:
- DIV_MAX, 256, largest programmable divide ratio.
- DIV_WIDTH, log2(DIV_MAX)+1, width of `div` and of the internal phase counter.
- BURST_WIDTH, 8, width of `burst_len`. Only used with the optional feature.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- div  input  DIV_WIDTH  requested divide ratio; values 0 and 1 both mean 1; values above DIV_MAX saturate to DIV_MAX.
- div_load  input  1  capture `div` this cycle.
- start  input  1  enter continuous RUN.
- stop  input  1  return to IDLE.
- single  input  1  produce exactly one tick, then return to IDLE.
- tick  output  1  registered strobe; drives the counter's `enable`.
- running  output  1  high in RUN or ONESHOT.
- done  output  1  one-cycle pulse when ONESHOT (or a burst) completes.
- burst_len  input  BURST_WIDTH  only with COUNTER_PRESCALER_BURST_EN.

Behaviour:
- Reset (asynchronous, reset=0), all values hold while reset is low:
  - state=IDLE, ph=0, tick=0, running=0, done=0.
  - div_act=1, div_pend=1, pend_vld=0.
- States: IDLE, RUN, ONESHOT. `running` is registered and equals (state != IDLE).
- IDLE:
  - start -> RUN.
  - single (without start) -> ONESHOT.
  - start and single together -> RUN.
  - ph is held at 0.
- RUN:
  - ph increments each cycle.
  - When ph == div_act-1: ph <= 0 and tick <= 1 in the following cycle; otherwise tick <= 0.
  - First tick is visible DIV cycles after the edge that sampled start; each later tick follows DIV cycles after the previous one.
  - With DIV=1, tick stays high every cycle from the cycle after start.
- ONESHOT: same phase counting. On wrap: tick <= 1, done <= 1, state -> IDLE. Both tick and done are visible in the same cycle.
- stop in RUN or ONESHOT:
  - Next state is IDLE, ph <= 0, tick <= 0, done stays 0.
  - stop wins over a wrap in the same cycle, so no tick is produced.
- Priority: stop > start > single. start or single while not IDLE is ignored, with no phase restart.
- Divide-ratio updates (div_load):
  - The captured value is normalised (0 -> 1, >DIV_MAX -> DIV_MAX).
  - In IDLE, or in the same cycle as an accepted start/single: written straight to div_act.
  - Otherwise: written to div_pend with pend_vld=1. div_act <= div_pend at the next wrap, then pend_vld <= 0.
  - A second div_load before the wrap overwrites div_pend; the last one wins.
  - The period in progress is never shortened or stretched.
- Stale pending ratio: on any transition into IDLE with pend_vld=1, div_pend is applied immediately.
- ph width is DIV_WIDTH, unsigned. The ph == div_act-1 compare is evaluated at DIV_WIDTH bits, so no wrap-around aliasing at DIV_MAX.
- Reset asserted mid-period: outputs clear asynchronously. After reset is released, no tick occurs until a new start or single.

Optional Feature:
- Macro: COUNTER_PRESCALER_BURST_EN.
- With the macro defined:
  - `burst_len` port is present and sampled at an accepted start.
  - A nonzero value limits RUN to exactly burst_len ticks. Its final tick carries done=1 and the state returns to IDLE.
  - burst_len=0 means unbounded.
  - stop aborts the burst with no done pulse.
- Without the macro: port absent, RUN is unbounded, and done fires only from ONESHOT.

Decomposition:
- Package counter_pkg holds:
  - typedef enum {IDLE, RUN, ONESHOT} prescaler_state_t;
  - constant DIV_RESET = 1;
  - function div_normalise(div, DIV_MAX).
- One natural sub-module, counter_prescaler_phase: the ph register plus the wrap compare. Inputs: clear, advance, div_act. Output: wrap. The FSM, the div staging and the burst logic stay in the top level.

Test Plan:
- Reset, then div_load with div=4 while IDLE, start at cycle 0 -> tick high at cycles 4, 8, 12. running=1 from cycle 1.
- div=1, start -> tick high every cycle from cycle 1. stop at cycle 5 -> tick=0 from cycle 6, running=0.
- div=5 in RUN, div_load with div=2 at cycle 2 of a period -> current period still ends at 5 cycles; subsequent ticks every 2 cycles. div=0 load -> period 1.
- single with div=3 -> exactly one tick with done=1 at cycle 3, then IDLE. start+stop in the same cycle -> stays IDLE, no tick.
- Pull reset low at cycle 2 of a div=4 period -> tick, running, done clear immediately. After release, no tick without a new start. BURST_EN: burst_len=3, div=2 -> ticks at 2, 4, 6; done at 6; IDLE after.

Source files
------------

// File: rtl/counter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// counter_pkg : shared types, reset ratio and divide-ratio normaliser
// Rev 1.0
// ----------------------------------------------------------------------------
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ONESHOT = 2'd2
  } prescaler_state_t;

  localparam int DIV_RESET = 1;

  // 0 and 1 both mean "tick every cycle"; anything above div_max saturates.
  function automatic int div_normalise(input int div, input int div_max);
    if (div <= 1) begin
      return 1;
    end else if (div > div_max) begin
      return div_max;
    end
    return div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescaler_phase.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// counter_prescaler_phase : phase register and wrap detect for the prescaler
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_prescaler_phase #(
  parameter int DIV_WIDTH = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIV_WIDTH-1:0] div_act,
  output logic                 wrap
);

  localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_ph;
  logic [DIV_WIDTH-1:0] w_last;

  // Full-width compare, so a ratio of DIV_MAX cannot alias onto a short one.
  assign w_last = div_act - c_ONE;
  assign wrap   = advance && (r_ph == w_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ph <= '0;
    end else if (clear || wrap) begin
      r_ph <= '0;
    end else if (advance) begin
      r_ph <= r_ph + c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// counter_prescaler : enable strobe every DIV cycles, start/stop/one-shot FSM
// Optional bounded bursts with COUNTER_PRESCALER_BURST_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int DIV_MAX   = 256,
  parameter int DIV_WIDTH = $clog2(DIV_MAX) + 1
`ifdef COUNTER_PRESCALER_BURST_EN
  ,
  parameter int BURST_WIDTH = 8
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic                   div_load,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   single,
  output logic                   tick,
  output logic                   running,
  output logic                   done
`ifdef COUNTER_PRESCALER_BURST_EN
  ,
  input  logic [BURST_WIDTH-1:0] burst_len
`endif
);

  localparam logic [1:0]           c_S_IDLE    = IDLE;
  localparam logic [1:0]           c_S_RUN     = RUN;
  localparam logic [1:0]           c_S_ONESHOT = ONESHOT;
  localparam logic [DIV_WIDTH-1:0] c_DIV_RESET = DIV_WIDTH'(DIV_RESET);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 r_tick;
  logic                 r_running;
  logic                 r_done;
  logic [DIV_WIDTH-1:0] r_div_act;
  logic [DIV_WIDTH-1:0] r_div_pend;
  logic                 r_pend_vld;
  logic [DIV_WIDTH-1:0] w_div_norm;
  logic                 w_idle;
  logic                 w_stop;
  logic                 w_start_acc;
  logic                 w_single_acc;
  logic                 w_wrap_raw;
  logic                 w_wrap;
  logic                 w_done_nxt;
  logic                 w_burst_end;
  logic                 w_to_idle;

  assign w_div_norm   = DIV_WIDTH'(div_normalise(32'(div), DIV_MAX));
  assign w_idle       = (r_state == c_S_IDLE);
  assign w_stop       = stop && !w_idle;
  assign w_start_acc  = w_idle && start && !stop;
  assign w_single_acc = w_idle && single && !start && !stop;
  // A stop in the wrap cycle suppresses the tick.
  assign w_wrap       = w_wrap_raw && !stop;

  counter_prescaler_phase #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_phase (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_idle || stop),
    .advance (!w_idle),
    .div_act (r_div_act),
    .wrap    (w_wrap_raw)
  );

`ifdef COUNTER_PRESCALER_BURST_EN
  localparam logic [BURST_WIDTH-1:0] c_BURST_ONE = BURST_WIDTH'(1);

  logic [BURST_WIDTH-1:0] r_burst_left;

  // Zero means unbounded: the count only moves while it is nonzero.
  assign w_burst_end = (r_state == c_S_RUN) && w_wrap && (r_burst_left == c_BURST_ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_burst_left <= '0;
    end else if (w_start_acc) begin
      r_burst_left <= burst_len;
    end else if ((r_state == c_S_RUN) && w_wrap && (r_burst_left != '0)) begin
      r_burst_left <= r_burst_left - c_BURST_ONE;
    end
  end
`else
  assign w_burst_end = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = c_S_RUN;
        end else if (w_single_acc) begin
          w_state_nxt = c_S_ONESHOT;
        end
      end
      c_S_RUN: begin
        if (w_stop) begin
          w_state_nxt = c_S_IDLE;
        end else if (w_burst_end) begin
          w_state_nxt = c_S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      c_S_ONESHOT: begin
        if (w_stop) begin
          w_state_nxt = c_S_IDLE;
        end else if (w_wrap) begin
          w_state_nxt = c_S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  assign w_to_idle = !w_idle && (w_state_nxt == c_S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_S_IDLE;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_wrap;
      r_running <= (w_state_nxt != c_S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  // New ratios only take effect on a period boundary; leaving the active
  // states flushes anything still staged so IDLE never holds a stale value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div_act  <= c_DIV_RESET;
      r_div_pend <= c_DIV_RESET;
      r_pend_vld <= 1'b0;
    end else if (w_idle) begin
      if (div_load) begin
        r_div_act <= w_div_norm;
      end
    end else if (w_to_idle) begin
      if (div_load) begin
        r_div_act <= w_div_norm;
      end else if (r_pend_vld) begin
        r_div_act <= r_div_pend;
      end
      r_pend_vld <= 1'b0;
    end else begin
      if (w_wrap && r_pend_vld) begin
        r_div_act <= r_div_pend;
      end
      if (div_load) begin
        r_div_pend <= w_div_norm;
        r_pend_vld <= 1'b1;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign tick    = r_tick;
  assign running = r_running;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_prescaler : directed stimulus, timestamp model plus literal checks
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_counter_prescaler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] div = '0;
  logic       div_load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       single = 1'b0;
  logic       tick;
  logic       running;
  logic       done;
`ifdef COUNTER_PRESCALER_BURST_EN
  logic [7:0] burst_len = '0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  counter_prescaler dut (
    .clock    (clock),
    .reset    (reset),
    .div      (div),
    .div_load (div_load),
    .start    (start),
    .stop     (stop),
    .single   (single),
    .tick     (tick),
    .running  (running),
    .done     (done)
`ifdef COUNTER_PRESCALER_BURST_EN
    ,
    .burst_len(burst_len)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each active run keeps the absolute edge number of its next tick.
  function automatic int norm(input int d);
    if (d <= 1) return 1;
    if (d > 256) return 256;
    return d;
  endfunction

  longint cyc    = 0;
  longint m_next = 0;
  int     m_mode = 0;   // 0 idle, 1 continuous, 2 one-shot
  int     m_div  = 1;
  int     m_pend = 1;
  int     m_left = 0;
  bit     m_pvld = 0;
  logic   e_tick = 1'b0;
  logic   e_run  = 1'b0;
  logic   e_done = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_div = 1; m_pend = 1; m_pvld = 0; m_left = 0;
      e_tick = 1'b0; e_run = 1'b0; e_done = 1'b0;
    end else begin
      cyc++;
      e_tick = 1'b0;
      e_done = 1'b0;
      if (m_mode == 0) begin
        if (!stop && (start || single)) begin
          if (div_load) m_div = norm(int'(div));
          m_mode = start ? 1 : 2;
          m_next = cyc + m_div;
`ifdef COUNTER_PRESCALER_BURST_EN
          m_left = start ? int'(burst_len) : 0;
`else
          m_left = 0;
`endif
        end else if (div_load) begin
          m_div = norm(int'(div));
        end
      end else if (stop) begin
        m_mode = 0;
        if (div_load) m_div = norm(int'(div));
        else if (m_pvld) m_div = m_pend;
        m_pvld = 0;
      end else begin
        if (cyc == m_next) begin
          e_tick = 1'b1;
          if (m_pvld) begin m_div = m_pend; m_pvld = 0; end
          m_next = cyc + m_div;
          if (m_mode == 2) begin
            e_done = 1'b1; m_mode = 0;
          end else if (m_left != 0) begin
            if (m_left == 1) begin e_done = 1'b1; m_mode = 0; end
            m_left--;
          end
        end
        if (div_load) begin m_pend = norm(int'(div)); m_pvld = 1; end
        if (m_mode == 0 && m_pvld) begin m_div = m_pend; m_pvld = 0; end
      end
      e_run = (m_mode != 0);
    end
  end

  always @(negedge clock) begin
    chk("model_tick", 64'(tick), 64'(e_tick));
    chk("model_running", 64'(running), 64'(e_run));
    chk("model_done", 64'(done), 64'(e_done));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] m_tick, m_done;
  int first;

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("reset_tick", 64'(tick), 64'd0);
    chk("reset_running", 64'(running), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    step();

    // div=4 continuous: ticks at 4, 8, 12
    div = 9'd4; div_load = 1'b1; step(); div_load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    m_tick = '0;
    for (int k = 0; k < 13; k++) begin
      m_tick[k] = tick;
      if (k == 1) chk("t1_running", 64'(running), 64'd1);
      step();
    end
    chk("t1_ticks", 64'(m_tick), 64'h1110);
    stop = 1'b1; step(); stop = 1'b0; step();

    // div=1: tick every cycle, stop during cycle 5
    div = 9'd1; div_load = 1'b1; start = 1'b1; step();
    div_load = 1'b0; start = 1'b0;
    m_tick = '0;
    for (int k = 0; k < 9; k++) begin
      m_tick[k] = tick;
      stop = (k == 5);
      step();
    end
    stop = 1'b0;
    chk("t2_ticks", 64'(m_tick), 64'h03E);
    chk("t2_running", 64'(running), 64'd0);

    // div=5 with a mid-period reload to 2, then a reload of 0
    div = 9'd5; div_load = 1'b1; start = 1'b1; step();
    div_load = 1'b0; start = 1'b0;
    m_tick = '0;
    for (int k = 0; k < 18; k++) begin
      m_tick[k] = tick;
      div_load = (k == 2) || (k == 12);
      div = (k == 2) ? 9'd2 : 9'd0;
      step();
    end
    div_load = 1'b0;
    chk("t3_ticks", 64'(m_tick), 64'h3AAA0);
    stop = 1'b1; step(); stop = 1'b0; step();

    // one-shot with div=3
    div = 9'd3; div_load = 1'b1; single = 1'b1; step();
    div_load = 1'b0; single = 1'b0;
    m_tick = '0; m_done = '0;
    for (int k = 0; k < 7; k++) begin
      m_tick[k] = tick;
      m_done[k] = done;
      step();
    end
    chk("t4_ticks", 64'(m_tick), 64'h08);
    chk("t4_done", 64'(m_done), 64'h08);
    chk("t4_running", 64'(running), 64'd0);

    // start and stop together from IDLE: nothing happens
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    m_tick = '0;
    for (int k = 0; k < 6; k++) begin
      m_tick[0] = m_tick[0] | tick | running;
      step();
    end
    chk("t4_startstop", 64'(m_tick), 64'd0);

    // reset mid-period, then no ticks without a fresh start
    div = 9'd4; div_load = 1'b1; start = 1'b1; step();
    div_load = 1'b0; start = 1'b0;
    step(); step();
    chk("t5_running_before", 64'(running), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_tick", 64'(tick), 64'd0);
    chk("t5_running", 64'(running), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    step(); step();
    reset = 1'b1;
    m_tick = '0;
    for (int k = 0; k < 10; k++) begin
      m_tick[k] = tick | running;
      step();
    end
    chk("t5_after_release", 64'(m_tick), 64'd0);

    // ratio above DIV_MAX saturates to 256
    div = 9'd300; div_load = 1'b1; single = 1'b1; step();
    div_load = 1'b0; single = 1'b0;
    first = -1;
    for (int k = 0; k < 300; k++) begin
      if (tick && first < 0) first = k;
      step();
    end
    chk("t6_sat_period", 64'(first), 64'd256);

`ifdef COUNTER_PRESCALER_BURST_EN
    // burst of 3 ticks at div=2
    burst_len = 8'd3; div = 9'd2; div_load = 1'b1; start = 1'b1; step();
    div_load = 1'b0; start = 1'b0; burst_len = '0;
    m_tick = '0; m_done = '0;
    for (int k = 0; k < 9; k++) begin
      m_tick[k] = tick;
      m_done[k] = done;
      step();
    end
    chk("t7_ticks", 64'(m_tick), 64'h54);
    chk("t7_done", 64'(m_done), 64'h40);
    chk("t7_running", 64'(running), 64'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
